// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring-mode CORDIC: rotates an I/Q sample onto +x one micro-rotation
// per clock and returns the gain-scaled magnitude and the phase angle.
module cordic_vectoring_iter #(
    parameter int XY_WIDTH   = 16,
    parameter int Z_WIDTH    = 16,
    parameter int ITERATIONS = 12
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [XY_WIDTH-1:0] xin,
    input  logic signed [XY_WIDTH-1:0] yin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XY_WIDTH+1:0]        mag,
    output logic [Z_WIDTH-1:0]         phase
);
    localparam int W = XY_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          i_q, i_d;
    logic signed [W-1:0] x_q, x_d, y_q, y_d;
    logic signed [W-1:0] xe, ye, xs, ys;
    logic [Z_WIDTH-1:0]  z_q, z_d, phase_q, phase_d, atan_c;
    logic [W-1:0]        mag_q, mag_d;

    function automatic logic [Z_WIDTH-1:0] atan_lut(input logic [3:0] k);
        int unsigned v;
        case (k)
            4'd0:    v = 8192;
            4'd1:    v = 4836;
            4'd2:    v = 2555;
            4'd3:    v = 1297;
            4'd4:    v = 651;
            4'd5:    v = 326;
            4'd6:    v = 163;
            4'd7:    v = 81;
            4'd8:    v = 41;
            4'd9:    v = 20;
            4'd10:   v = 10;
            4'd11:   v = 5;
            default: v = 0;
        endcase
        return Z_WIDTH'(v);
    endfunction

    // Two guard bits let -2^(XY_WIDTH-1) negate and the gain-K growth fit without wrap.
    assign xe     = {{2{xin[XY_WIDTH-1]}}, xin};
    assign ye     = {{2{yin[XY_WIDTH-1]}}, yin};
    assign xs     = x_q >>> i_q;
    assign ys     = y_q >>> i_q;
    assign atan_c = atan_lut(i_q);

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        mag_d   = mag_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (xe[W-1]) begin
                        x_d = -xe;
                        y_d = -ye;
                        z_d = {1'b1, {(Z_WIDTH-1){1'b0}}};
                    end else begin
                        x_d = xe;
                        y_d = ye;
                        z_d = '0;
                    end
                    i_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!y_q[W-1]) begin
                    x_d = x_q + ys;
                    y_d = y_q - xs;
                    z_d = z_q + atan_c;
                end else begin
                    x_d = x_q - ys;
                    y_d = y_q + xs;
                    z_d = z_q - atan_c;
                end
                if (i_q == 4'(ITERATIONS - 1)) begin
                    mag_d   = $unsigned(x_d);
                    phase_d = z_d;
                    state_d = DONE;
                end else begin
                    i_d = i_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            mag_q   <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            mag_q   <= mag_d;
            phase_q <= phase_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign mag       = mag_q;
    assign phase     = phase_q;
endmodule
